// File: rtl/pe_pkg.sv
// pe_pkg: opcode and scheduler-state encodings shared by the PE issue path
package pe_pkg;
    localparam int OPCODE_WIDTH = 4;
    typedef enum logic [OPCODE_WIDTH-1:0] {
        NOOP          = 4'd0,
        ADD           = 4'd1,
        SUB           = 4'd2,
        MUL           = 4'd3,
        DOTP          = 4'd4,
        STORE_TEMP_S1 = 4'd5,
        STORE_TEMP_S2 = 4'd6,
        STORE_RESULT  = 4'd7,
        STOP          = 4'd8
    } opcode_t;
    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_DRAIN, S_STOPPED, S_ERR} sched_state_t;
    function automatic logic is_vector_op(input logic [OPCODE_WIDTH-1:0] op);
        return op inside {ADD, SUB, MUL, DOTP};
    endfunction
endpackage

// File: rtl/pe_issue_scheduler_if.sv
// pe_issue_scheduler_if: host command valid/ready handshake into the issue scheduler
interface pe_issue_scheduler_if import pe_pkg::*; #(
    parameter int ADDR_W = 10,
    parameter int LEN_W  = 8
);
    logic                    cmd_valid;
    logic                    cmd_ready;
    logic [OPCODE_WIDTH-1:0] cmd_op;
    logic [ADDR_W-1:0]       cmd_src_a;
    logic [ADDR_W-1:0]       cmd_src_b;
    logic [ADDR_W-1:0]       cmd_dst;
    logic [LEN_W-1:0]        cmd_len;
    modport master (output cmd_valid, cmd_op, cmd_src_a, cmd_src_b, cmd_dst, cmd_len, input cmd_ready);
    modport slave  (input cmd_valid, cmd_op, cmd_src_a, cmd_src_b, cmd_dst, cmd_len, output cmd_ready);
endinterface

// File: rtl/pe_wb_tracker.sv
// pe_wb_tracker: shift register of in-flight results, read at a latency-selected tap
module pe_wb_tracker #(
    parameter int DEPTH = 4,
    parameter int OFF_W = 8,
    localparam int TAP_W = DEPTH > 1 ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             push_scalar,
    input  logic [OFF_W-1:0] push_off,
    input  logic [TAP_W-1:0] tap,
    output logic             out_valid,
    output logic             out_scalar,
    output logic [OFF_W-1:0] out_off,
    output logic             pending
);
    logic [DEPTH-1:0] v;
    logic [DEPTH-1:0] sc;
    logic [OFF_W-1:0] off [DEPTH];
    // shift every cycle; an entry is retired once it passes the tap so it can never fire later
    always_ff @(posedge clk) begin
        if (rst) v <= '0;
        else begin
            v[0] <= push;
            for (int i = 1; i < DEPTH; i++) v[i] <= v[i-1] && (TAP_W'(i-1) != tap);
        end
        sc[0]  <= push_scalar;
        off[0] <= push_off;
        for (int i = 1; i < DEPTH; i++) begin
            sc[i]  <= sc[i-1];
            off[i] <= off[i-1];
        end
    end
    // results still upstream of the tap keep the command from completing
    always_comb begin
        pending = 1'b0;
        for (int i = 0; i < DEPTH; i++) if (TAP_W'(i) < tap) pending = pending | v[i];
    end
    assign out_valid  = v[tap];
    assign out_scalar = sc[tap];
    assign out_off    = off[tap];
endmodule

// File: rtl/pe_issue_scheduler.sv
// pe_issue_scheduler: expands vector commands into per-cycle PE issue beats and write-back strobes
module pe_issue_scheduler import pe_pkg::*; #(
    parameter int ADDR_W   = 10,
    parameter int LEN_W    = 8,
    parameter int ELEM_LAT = 2,
    parameter int DOTP_LAT = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    pe_issue_scheduler_if.slave     cmd,
    input  logic                    hold,
    output logic                    issue_valid,
    output logic [OPCODE_WIDTH-1:0] issue_opcode,
    output logic [ADDR_W-1:0]       issue_addr_a,
    output logic [ADDR_W-1:0]       issue_addr_b,
    output logic                    issue_acc_clr,
    output logic                    wb_valid,
    output logic [ADDR_W-1:0]       wb_addr,
    output logic                    wb_scalar,
    output logic                    done,
    output logic                    err,
    output logic                    halted
);
    localparam int DEPTH = ELEM_LAT > DOTP_LAT ? ELEM_LAT : DOTP_LAT;
    localparam int TAP_W = DEPTH > 1 ? $clog2(DEPTH) : 1;
    sched_state_t            state, state_n;
    logic [OPCODE_WIDTH-1:0] op;
    logic [ADDR_W-1:0]       src_a, src_b, dst;
    logic [LEN_W-1:0]        len, k;
    logic                    accept, beat, last_beat, is_dotp;
    logic                    trk_valid, trk_scalar, pending;
    logic [LEN_W-1:0]        trk_off;
    assign cmd.cmd_ready = state == S_IDLE && !rst;
    assign accept        = cmd.cmd_valid && cmd.cmd_ready;
    assign is_dotp       = op == DOTP;
    assign beat          = state == S_ISSUE && !hold;
    assign last_beat     = k == len - 1'b1;
    assign issue_valid   = beat || (state == S_STOPPED && !halted);
    assign issue_opcode  = issue_valid ? op : NOOP;
    assign issue_addr_a  = issue_valid ? src_a + ADDR_W'(k) : '0;
    assign issue_addr_b  = issue_valid ? src_b + ADDR_W'(k) : '0;
    assign issue_acc_clr = beat && is_dotp && k == '0;
    assign wb_valid      = trk_valid;
    assign wb_scalar     = trk_valid && trk_scalar;
    assign wb_addr       = trk_valid ? dst + ADDR_W'(trk_off) : '0;
    assign done          = (state == S_DRAIN && trk_valid && !pending) || state == S_ERR;
    assign err           = state == S_ERR;
    // state register; halted latches after the single STOP issue cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            halted <= 1'b0;
        end else begin
            state <= state_n;
            if (state == S_STOPPED) halted <= 1'b1;
        end
    end
    // latch command fields on acceptance and step the beat counter on each issued beat
    always_ff @(posedge clk) begin
        if (accept) begin
            op    <= cmd.cmd_op;
            src_a <= cmd.cmd_src_a;
            src_b <= cmd.cmd_src_b;
            dst   <= cmd.cmd_dst;
            len   <= cmd.cmd_len;
            k     <= '0;
        end else if (beat) k <= k + 1'b1;
    end
    // next-state: classify commands at acceptance, leave ISSUE after the last beat, DRAIN until done
    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:  if (accept) state_n = is_vector_op(cmd.cmd_op) && cmd.cmd_len != '0 ? S_ISSUE :
                                           cmd.cmd_op == STOP ? S_STOPPED : S_ERR;
            S_ISSUE: if (beat && last_beat) state_n = S_DRAIN;
            S_DRAIN: if (done) state_n = S_IDLE;
            S_ERR:   state_n = S_IDLE;
            default: ;
        endcase
    end
    pe_wb_tracker #(.DEPTH(DEPTH), .OFF_W(LEN_W)) u_trk (
        .clk         (clk),
        .rst         (rst),
        .push        (beat && (!is_dotp || last_beat)),
        .push_scalar (is_dotp),
        .push_off    (is_dotp ? '0 : k),
        .tap         (is_dotp ? TAP_W'(DOTP_LAT - 1) : TAP_W'(ELEM_LAT - 1)),
        .out_valid   (trk_valid),
        .out_scalar  (trk_scalar),
        .out_off     (trk_off),
        .pending     (pending)
    );
endmodule

// File: tb/tb_pe_issue_scheduler.sv
// tb_pe_issue_scheduler: randomized and directed commands checked against a per-cycle schedule model
module tb_pe_issue_scheduler;
    import pe_pkg::*;
    localparam int ADDR_W = 10, LEN_W = 8, ELEM_LAT = 2, DOTP_LAT = 4, NR = 2048;
    logic clk = 1'b0, rst = 1'b1, hold = 1'b0;
    logic issue_valid, issue_acc_clr, wb_valid, wb_scalar, done, err, halted;
    logic [3:0] issue_opcode;
    logic [9:0] issue_addr_a, issue_addr_b, wb_addr;
    int n_checks = 0, n_fail = 0;
    logic       e_iv [NR], e_clr [NR], e_wb [NR], e_sc [NR], hv [NR];
    logic [9:0] e_a [NR], e_b [NR], e_wa [NR];
    int done_r;

    pe_issue_scheduler_if #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) cmd ();

    pe_issue_scheduler #(.ADDR_W(ADDR_W), .LEN_W(LEN_W), .ELEM_LAT(ELEM_LAT), .DOTP_LAT(DOTP_LAT)) dut (
        .clk           (clk),
        .rst           (rst),
        .cmd           (cmd),
        .hold          (hold),
        .issue_valid   (issue_valid),
        .issue_opcode  (issue_opcode),
        .issue_addr_a  (issue_addr_a),
        .issue_addr_b  (issue_addr_b),
        .issue_acc_clr (issue_acc_clr),
        .wb_valid      (wb_valid),
        .wb_addr       (wb_addr),
        .wb_scalar     (wb_scalar),
        .done          (done),
        .err           (err),
        .halted        (halted)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic garbage_cmd(input logic valid);
        cmd.cmd_valid = valid;
        cmd.cmd_op    = 4'($urandom);
        cmd.cmd_src_a = 10'($urandom);
        cmd.cmd_src_b = 10'($urandom);
        cmd.cmd_dst   = 10'($urandom);
        cmd.cmd_len   = 8'($urandom);
    endtask

    // builds the expected cycle-by-cycle schedule from the command rules, then drives and compares
    task automatic run_cmd(input logic [3:0] op, input logic [9:0] a, input logic [9:0] b,
                           input logic [9:0] d, input logic [7:0] len, input logic [31:0] hmask, input int hpct);
        int k, last;
        logic legal;
        legal = (op inside {4'd1, 4'd2, 4'd3, 4'd4}) && len != 8'd0;
        for (int r = 0; r < NR; r++) begin
            e_iv[r] = 0; e_clr[r] = 0; e_wb[r] = 0; e_sc[r] = 0;
            e_a[r] = 0; e_b[r] = 0; e_wa[r] = 0;
            hv[r] = r > 0 && ((r < 32 && hmask[r]) || int'($urandom_range(0, 99)) < hpct);
        end
        if (legal) begin
            k = 0;
            last = 0;
            for (int r = 1; k < int'(len) && r < NR - 8; r++) begin
                if (!hv[r]) begin
                    e_iv[r]  = 1;
                    e_a[r]   = a + 10'(k);
                    e_b[r]   = b + 10'(k);
                    e_clr[r] = op == 4'd4 && k == 0;
                    if (op != 4'd4) begin
                        e_wb[r+ELEM_LAT] = 1;
                        e_wa[r+ELEM_LAT] = d + 10'(k);
                    end
                    k++;
                    last = r;
                end
            end
            if (op == 4'd4) begin
                e_wb[last+DOTP_LAT] = 1;
                e_wa[last+DOTP_LAT] = d;
                e_sc[last+DOTP_LAT] = 1;
                done_r = last + DOTP_LAT;
            end else done_r = last + ELEM_LAT;
        end else done_r = 1;
        step();
        cmd.cmd_valid = 1; cmd.cmd_op = op; cmd.cmd_src_a = a; cmd.cmd_src_b = b;
        cmd.cmd_dst = d; cmd.cmd_len = len; hold = 0;
        #3;
        check("accept_ready", 32'(cmd.cmd_ready), 32'd1);
        for (int r = 1; r <= done_r + 1; r++) begin
            step();
            hold = hv[r];
            garbage_cmd(r <= done_r);
            #3;
            check("issue_valid", 32'(issue_valid), 32'(e_iv[r]));
            check("issue_opcode", 32'(issue_opcode), e_iv[r] ? 32'(op) : 32'd0);
            if (e_iv[r]) begin
                check("issue_addr_a", 32'(issue_addr_a), 32'(e_a[r]));
                check("issue_addr_b", 32'(issue_addr_b), 32'(e_b[r]));
            end
            check("acc_clr", 32'(issue_acc_clr), 32'(e_clr[r]));
            check("wb_valid", 32'(wb_valid), 32'(e_wb[r]));
            if (e_wb[r]) begin
                check("wb_addr", 32'(wb_addr), 32'(e_wa[r]));
                check("wb_scalar", 32'(wb_scalar), 32'(e_sc[r]));
            end
            check("done", 32'(done), 32'(r == done_r));
            check("err", 32'(err), 32'(r == done_r && !legal));
            check("cmd_ready", 32'(cmd.cmd_ready), 32'(r > done_r));
            check("halted", 32'(halted), 32'd0);
        end
        hold = 0;
    endtask

    initial begin
        logic [3:0] op;
        int sel;
        garbage_cmd(1'b0);
        rst = 1;
        repeat (3) step();
        #3;
        check("rst_issue_valid", 32'(issue_valid), 32'd0);
        check("rst_opcode", 32'(issue_opcode), 32'd0);
        check("rst_wb_valid", 32'(wb_valid), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_cmd_ready", 32'(cmd.cmd_ready), 32'd0);
        step();
        rst = 0;
        #3;
        check("ready_after_rst", 32'(cmd.cmd_ready), 32'd1);

        run_cmd(4'd1, 10'h010, 10'h020, 10'h030, 8'd3, 32'h0, 0);
        run_cmd(4'd4, 10'h040, 10'h080, 10'h100, 8'd4, 32'h0, 0);
        run_cmd(4'd3, 10'h005, 10'h105, 10'h205, 8'd4, 32'h0000_000C, 0);
        run_cmd(4'd1, 10'h3FF, 10'h3FE, 10'h3FE, 8'd3, 32'h0, 0);
        run_cmd(4'd1, 10'h001, 10'h002, 10'h003, 8'd0, 32'h0, 0);
        run_cmd(4'd6, 10'h001, 10'h002, 10'h003, 8'd2, 32'h0, 0);
        run_cmd(4'd0, 10'h001, 10'h002, 10'h003, 8'd5, 32'h0, 0);
        run_cmd(4'd2, 10'h200, 10'h300, 10'h3F0, 8'd255, 32'h0, 0);
        run_cmd(4'd4, 10'h123, 10'h321, 10'h2AA, 8'd255, 32'h0, 20);
        run_cmd(4'd4, 10'h011, 10'h022, 10'h033, 8'd1, 32'h0000_0006, 30);

        for (int i = 0; i < 40; i++) begin
            sel = int'($urandom_range(0, 19));
            op = sel < 16 ? 4'(1 + sel % 4) : sel == 16 ? 4'd0 : 4'($urandom_range(5, 15));
            if (op == 4'd8) op = 4'd7;
            run_cmd(op, 10'($urandom), 10'($urandom), 10'($urandom),
                    $urandom_range(0, 9) == 0 ? 8'd0 : 8'($urandom_range(1, 40)),
                    $urandom, int'($urandom_range(0, 40)));
        end

        step();
        cmd.cmd_valid = 1; cmd.cmd_op = 4'd4; cmd.cmd_src_a = 10'h0; cmd.cmd_src_b = 10'h0;
        cmd.cmd_dst = 10'h100; cmd.cmd_len = 8'd4;
        #3;
        check("dotp_rst_accept", 32'(cmd.cmd_ready), 32'd1);
        for (int r = 1; r <= 5; r++) begin
            step();
            cmd.cmd_valid = 0;
            #3;
        end
        step();
        rst = 1;
        #3;
        step();
        rst = 0;
        #3;
        check("dotp_rst_ready", 32'(cmd.cmd_ready), 32'd1);
        for (int r = 0; r < 10; r++) begin
            check("dotp_rst_wb", 32'(wb_valid), 32'd0);
            check("dotp_rst_done", 32'(done), 32'd0);
            step();
            #3;
        end

        step();
        cmd.cmd_valid = 1; cmd.cmd_op = 4'd8; cmd.cmd_len = 8'($urandom);
        #3;
        check("stop_accept", 32'(cmd.cmd_ready), 32'd1);
        step();
        cmd.cmd_op = 4'd1; cmd.cmd_len = 8'd1; hold = 1;
        #3;
        check("stop_issue_valid", 32'(issue_valid), 32'd1);
        check("stop_opcode", 32'(issue_opcode), 32'd8);
        check("stop_halted_early", 32'(halted), 32'd0);
        check("stop_done", 32'(done), 32'd0);
        for (int r = 2; r < 22; r++) begin
            step();
            hold = 1'($urandom);
            #3;
            check("stop_halted", 32'(halted), 32'd1);
            check("stop_ready", 32'(cmd.cmd_ready), 32'd0);
            check("stop_no_issue", 32'(issue_valid), 32'd0);
            check("stop_no_done", 32'(done | wb_valid), 32'd0);
        end
        cmd.cmd_valid = 0;
        hold = 0;
        step();
        rst = 1;
        step();
        rst = 0;
        #3;
        check("halted_cleared", 32'(halted), 32'd0);
        check("ready_after_stop_rst", 32'(cmd.cmd_ready), 32'd1);
        run_cmd(4'd1, 10'h010, 10'h020, 10'h030, 8'd3, 32'h0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
